rob_param: RTL and testbench

- Parametrised reorder buffer; successor to the fixed 7-entry ROB in the out-of-order core.
- Sits between decode/rename (allocation, operand lookup) and the ALU/LSU result buses (writeback), and drives register-file commit and PC redirect.
- Adds over the previous generation: configurable depth, data width and writeback port count; a ready/valid allocation handshake; combinational operand lookup with same-cycle forwarding; branch-mispredict flush.

---
 rtl/rob_param.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rob_param.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// rob_param -- parametrised reorder buffer.
//
// Holds up to DEPTH = 2**TAG_W - 1 in-flight instructions, addressed by tags
// 1..DEPTH (tag 0 means "no producer"). Entries are allocated in program
// order at the tail and receive results from WB_PORTS writeback buses in any
// order. They retire one per cycle from the head, in order. A retiring
// entry flagged as mispredicted redirects the PC and empties the buffer.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   alloc_valid/alloc_ready   allocation handshake from decode/rename
//   alloc_kind, alloc_rd      instruction class (0 ALU,1 MEM,2 BR,3 JMP), dest reg
//   alloc_tag                 tag the next accepted allocation receives (tail)
//   lk_tag_*/lk_rdy_*/lk_val_*  combinational operand lookup with forwarding
//   wb_valid/tag/value/mispred/target  packed per-port result buses
//   ls_go, ls_tag             one-cycle go for the MEM entry at the head
//   commit_*                  registered retirement report
//   flush_valid, flush_pc     registered redirect pulse
//   count                     occupied entries
module rob_param #(
    parameter int TAG_W    = 3,
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [1:0]                alloc_kind,
    input  logic [4:0]                alloc_rd,
    output logic [TAG_W-1:0]          alloc_tag,
    input  logic [TAG_W-1:0]          lk_tag_a,
    input  logic [TAG_W-1:0]          lk_tag_b,
    output logic                      lk_rdy_a,
    output logic                      lk_rdy_b,
    output logic [XLEN-1:0]           lk_val_a,
    output logic [XLEN-1:0]           lk_val_b,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*XLEN-1:0]  wb_value,
    input  logic [WB_PORTS-1:0]       wb_mispred,
    input  logic [WB_PORTS*XLEN-1:0]  wb_target,
    output logic                      ls_go,
    output logic [TAG_W-1:0]          ls_tag,
    output logic                      commit_valid,
    output logic [4:0]                commit_rd,
    output logic [XLEN-1:0]           commit_value,
    output logic [TAG_W-1:0]          commit_tag,
    output logic                      flush_valid,
    output logic [XLEN-1:0]           flush_pc,
    output logic [TAG_W-1:0]          count
);

    localparam int DEPTH = (2 ** TAG_W) - 1;
    localparam logic [1:0] KIND_MEM = 2'd1;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ISSUED = 2'd2,
        ST_DONE   = 2'd3
    } ent_st_e;

    // Entry state is control (reset); the payload arrays are data (no reset).
    // Index 0 exists only so a tag indexes the arrays directly; it is never used.
    ent_st_e          st_q   [0:DEPTH];
    ent_st_e          st_d   [0:DEPTH];
    logic [1:0]       kind_q [0:DEPTH];
    logic [1:0]       kind_d [0:DEPTH];
    logic [4:0]       rd_q   [0:DEPTH];
    logic [4:0]       rd_d   [0:DEPTH];
    logic [XLEN-1:0]  val_q  [0:DEPTH];
    logic [XLEN-1:0]  val_d  [0:DEPTH];
    logic [XLEN-1:0]  tgt_q  [0:DEPTH];
    logic [XLEN-1:0]  tgt_d  [0:DEPTH];
    logic             misp_q [0:DEPTH];
    logic             misp_d [0:DEPTH];

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W-1:0] count_q, count_d;

    logic             commit_valid_q, commit_valid_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [XLEN-1:0]  commit_value_q, commit_value_d;
    logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
    logic             flush_valid_q, flush_valid_d;
    logic [XLEN-1:0]  flush_pc_q, flush_pc_d;
    logic             ls_go_q, ls_go_d;
    logic [TAG_W-1:0] ls_tag_q, ls_tag_d;

    logic                alloc_fire;
    logic                commit_fire;
    logic                flush_fire;
    logic                issue_fire;
    logic [WB_PORTS-1:0] wb_hit;

    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
        return (t == TAG_W'(DEPTH)) ? TAG_W'(1) : t + TAG_W'(1);
    endfunction

    assign alloc_ready = (count_q != TAG_W'(DEPTH));
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = (st_q[head_q] == ST_DONE);
    assign flush_fire  = commit_fire && misp_q[head_q];
    assign issue_fire  = (st_q[head_q] == ST_WAIT) && (kind_q[head_q] == KIND_MEM);

    // A writeback lands only on a live entry, or on the tail entry being
    // allocated on this very edge.
    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] != '0)) begin
                if ((st_q[wb_tag[p*TAG_W +: TAG_W]] != ST_EMPTY) ||
                    (alloc_fire && (wb_tag[p*TAG_W +: TAG_W] == tail_q))) begin
                    wb_hit[p] = 1'b1;
                end
            end
        end
    end

    // Operand lookup: stored DONE value first, else forward from a live
    // writeback this cycle. Ports are scanned high to low so port 0 wins.
    function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] t);
        logic [XLEN:0] r;
        r = '0;
        if (t != '0) begin
            if (st_q[t] == ST_DONE) begin
                r = {1'b1, val_q[t]};
            end else begin
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_hit[p] && (wb_tag[p*TAG_W +: TAG_W] == t)) begin
                        r = {1'b1, wb_value[p*XLEN +: XLEN]};
                    end
                end
            end
        end
        return r;
    endfunction

    assign {lk_rdy_a, lk_val_a} = lookup(lk_tag_a);
    assign {lk_rdy_b, lk_val_b} = lookup(lk_tag_b);

    always_comb begin
        st_d   = st_q;
        kind_d = kind_q;
        rd_d   = rd_q;
        val_d  = val_q;
        tgt_d  = tgt_q;
        misp_d = misp_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q + TAG_W'(alloc_fire) - TAG_W'(commit_fire);

        commit_valid_d = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_value_d = commit_value_q;
        commit_tag_d   = commit_tag_q;
        flush_valid_d  = 1'b0;
        flush_pc_d     = flush_pc_q;
        ls_go_d        = 1'b0;
        ls_tag_d       = ls_tag_q;

        if (issue_fire) begin
            ls_go_d          = 1'b1;
            ls_tag_d         = head_q;
            st_d[head_q]     = ST_ISSUED;
        end

        if (alloc_fire) begin
            st_d[tail_q]   = ST_WAIT;
            kind_d[tail_q] = alloc_kind;
            rd_d[tail_q]   = alloc_rd;
            tail_d         = next_tag(tail_q);
        end

        // Applied after allocation so a same-edge alloc+writeback ends DONE;
        // high-to-low order lets port 0 win a tag collision.
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_hit[p]) begin
                st_d[wb_tag[p*TAG_W +: TAG_W]]   = ST_DONE;
                val_d[wb_tag[p*TAG_W +: TAG_W]]  = wb_value[p*XLEN +: XLEN];
                tgt_d[wb_tag[p*TAG_W +: TAG_W]]  = wb_target[p*XLEN +: XLEN];
                misp_d[wb_tag[p*TAG_W +: TAG_W]] = wb_mispred[p];
            end
        end

        // Retirement reports the stored payload, not a same-edge rewrite.
        if (commit_fire) begin
            commit_valid_d = 1'b1;
            commit_rd_d    = rd_q[head_q];
            commit_value_d = val_q[head_q];
            commit_tag_d   = head_q;
            st_d[head_q]   = ST_EMPTY;
            head_d         = next_tag(head_q);
        end

        // Redirect wipes everything, including this edge's alloc and writebacks.
        if (flush_fire) begin
            flush_valid_d = 1'b1;
            flush_pc_d    = tgt_q[head_q];
            for (int i = 0; i <= DEPTH; i++) begin
                st_d[i] = ST_EMPTY;
            end
            head_d  = TAG_W'(1);
            tail_d  = TAG_W'(1);
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i <= DEPTH; i++) begin
                st_q[i] <= ST_EMPTY;
            end
            head_q         <= TAG_W'(1);
            tail_q         <= TAG_W'(1);
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_tag_q   <= '0;
            flush_valid_q  <= 1'b0;
            flush_pc_q     <= '0;
            ls_go_q        <= 1'b0;
            ls_tag_q       <= '0;
        end else begin
            st_q           <= st_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_value_q <= commit_value_d;
            commit_tag_q   <= commit_tag_d;
            flush_valid_q  <= flush_valid_d;
            flush_pc_q     <= flush_pc_d;
            ls_go_q        <= ls_go_d;
            ls_tag_q       <= ls_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        kind_q <= kind_d;
        rd_q   <= rd_d;
        val_q  <= val_d;
        tgt_q  <= tgt_d;
        misp_q <= misp_d;
    end

    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_value = commit_value_q;
    assign commit_tag   = commit_tag_q;
    assign flush_valid  = flush_valid_q;
    assign flush_pc     = flush_pc_q;
    assign ls_go        = ls_go_q;
    assign ls_tag       = ls_tag_q;
    assign count        = count_q;

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param -- bench for rob_param: directed scenarios followed by random
// traffic, all checked against a queue-based model of in-order retirement.
module tb_rob_param;

    localparam int TAG_W = 3;
    localparam int XLEN  = 32;
    localparam int WBP   = 2;
    localparam int DEPTH = 7;

    logic                  clk;
    logic                  rst;
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [1:0]            alloc_kind;
    logic [4:0]            alloc_rd;
    logic [TAG_W-1:0]      alloc_tag;
    logic [TAG_W-1:0]      lk_tag_a, lk_tag_b;
    logic                  lk_rdy_a, lk_rdy_b;
    logic [XLEN-1:0]       lk_val_a, lk_val_b;
    logic [WBP-1:0]        wb_valid;
    logic [WBP*TAG_W-1:0]  wb_tag;
    logic [WBP*XLEN-1:0]   wb_value;
    logic [WBP-1:0]        wb_mispred;
    logic [WBP*XLEN-1:0]   wb_target;
    logic                  ls_go;
    logic [TAG_W-1:0]      ls_tag;
    logic                  commit_valid;
    logic [4:0]            commit_rd;
    logic [XLEN-1:0]       commit_value;
    logic [TAG_W-1:0]      commit_tag;
    logic                  flush_valid;
    logic [XLEN-1:0]       flush_pc;
    logic [TAG_W-1:0]      count;

    rob_param #(.TAG_W(TAG_W), .XLEN(XLEN), .WB_PORTS(WBP)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .lk_tag_a(lk_tag_a), .lk_tag_b(lk_tag_b),
        .lk_rdy_a(lk_rdy_a), .lk_rdy_b(lk_rdy_b),
        .lk_val_a(lk_val_a), .lk_val_b(lk_val_b),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_mispred(wb_mispred), .wb_target(wb_target),
        .ls_go(ls_go), .ls_tag(ls_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_tag(commit_tag),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-tag payload plus a queue of tags in program order.
    bit          m_live[8], m_done[8], m_issued[8], m_misp[8];
    int          m_kind[8], m_rd[8];
    logic [31:0] m_val[8], m_tgt[8];
    int          m_order[$];
    int          m_next;
    bit          m_valid = 0;

    bit          exp_rst, exp_cv, exp_fv, exp_ls;
    int          exp_rd, exp_ctag, exp_ls_tag;
    logic [31:0] exp_val, exp_pc;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 8; i++) begin
            m_live[i] = 0; m_done[i] = 0; m_issued[i] = 0;
        end
        m_order.delete();
        m_next = 1;
    endtask

    function automatic int wtag(input int p);
        return int'(wb_tag[p*TAG_W +: TAG_W]);
    endfunction

    function automatic logic [32:0] m_lookup(input int t, input bit alloc_ok);
        if (t == 0) return 33'd0;
        if (m_done[t]) return {1'b1, m_val[t]};
        for (int p = 0; p < WBP; p++)
            if (wb_valid[p] && wtag(p) == t && (m_live[t] || (alloc_ok && t == m_next)))
                return {1'b1, wb_value[p*XLEN +: XLEN]};
        return 33'd0;
    endfunction

    task automatic model_step();
        bit alloc_ok, do_commit, do_flush, do_ls;
        bit written[8];
        int front;
        if (!rst) begin
            m_clear();
            m_valid = 1; exp_rst = 1; exp_cv = 0; exp_fv = 0; exp_ls = 0;
            exp_rd = 0; exp_val = 0; exp_ctag = 0; exp_pc = 0; exp_ls_tag = 0;
            return;
        end
        exp_rst   = 0;
        alloc_ok  = alloc_valid && (m_order.size() != DEPTH);
        front     = (m_order.size() > 0) ? m_order[0] : 0;
        do_commit = (m_order.size() > 0) && m_done[front];
        do_flush  = do_commit && m_misp[front];
        do_ls     = (m_order.size() > 0) && m_kind[front] == 1 && !m_done[front] && !m_issued[front];
        exp_ls = do_ls;
        if (do_ls) begin exp_ls_tag = front; m_issued[front] = 1; end
        exp_cv = do_commit;
        if (do_commit) begin exp_rd = m_rd[front]; exp_val = m_val[front]; exp_ctag = front; end
        exp_fv = do_flush;
        if (do_flush) begin exp_pc = m_tgt[front]; m_clear(); return; end
        if (alloc_ok) begin
            m_live[m_next] = 1; m_done[m_next] = 0; m_issued[m_next] = 0;
            m_kind[m_next] = int'(alloc_kind); m_rd[m_next] = int'(alloc_rd);
            m_order.push_back(m_next);
            m_next = (m_next == DEPTH) ? 1 : m_next + 1;
        end
        for (int i = 0; i < 8; i++) written[i] = 0;
        for (int p = 0; p < WBP; p++) begin
            int t;
            t = wtag(p);
            if (wb_valid[p] && t != 0 && m_live[t] && !written[t]) begin
                written[t] = 1;
                m_val[t]  = wb_value[p*XLEN +: XLEN];
                m_tgt[t]  = wb_target[p*XLEN +: XLEN];
                m_misp[t] = wb_mispred[p];
                m_done[t] = 1;
            end
        end
        if (do_commit) begin
            m_live[front] = 0; m_done[front] = 0;
            void'(m_order.pop_front());
        end
    endtask

    // One clock: check combinational outputs, advance model, check registers.
    task automatic cycle();
        bit alloc_ok;
        #1;
        if (m_valid) begin
            alloc_ok = alloc_valid && (m_order.size() != DEPTH);
            check("alloc_ready", 64'(alloc_ready), 64'(m_order.size() != DEPTH));
            check("alloc_tag", 64'(alloc_tag), 64'(m_next));
            check("lk_a", 64'({lk_rdy_a, lk_val_a}), 64'(m_lookup(int'(lk_tag_a), alloc_ok)));
            check("lk_b", 64'({lk_rdy_b, lk_val_b}), 64'(m_lookup(int'(lk_tag_b), alloc_ok)));
        end
        model_step();
        @(posedge clk);
        #1;
        check("commit_valid", 64'(commit_valid), 64'(exp_cv));
        check("flush_valid", 64'(flush_valid), 64'(exp_fv));
        check("ls_go", 64'(ls_go), 64'(exp_ls));
        check("count", 64'(count), 64'(m_order.size()));
        if (exp_cv || exp_rst) begin
            check("commit_rd", 64'(commit_rd), 64'(exp_rd));
            check("commit_value", 64'(commit_value), 64'(exp_val));
            check("commit_tag", 64'(commit_tag), 64'(exp_ctag));
        end
        if (exp_fv || exp_rst) check("flush_pc", 64'(flush_pc), 64'(exp_pc));
        if (exp_ls || exp_rst) check("ls_tag", 64'(ls_tag), 64'(exp_ls_tag));
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_kind = 0; alloc_rd = 0;
        wb_valid = '0; wb_tag = '0; wb_value = '0; wb_mispred = '0; wb_target = '0;
        lk_tag_a = '0; lk_tag_b = '0;
    endtask

    task automatic set_alloc(input int k, input int r);
        alloc_valid = 1; alloc_kind = 2'(k); alloc_rd = 5'(r);
    endtask

    task automatic set_wb(input int p, input int t, input logic [31:0] v,
                          input bit m, input logic [31:0] tg);
        wb_valid[p] = 1'b1;
        wb_tag[p*TAG_W +: TAG_W] = 3'(t);
        wb_value[p*XLEN +: XLEN] = v;
        wb_mispred[p] = m;
        wb_target[p*XLEN +: XLEN] = tg;
    endtask

    task automatic do_reset();
        idle(); rst = 0; cycle(); rst = 1;
    endtask

    int got_tags[$];

    initial begin
        idle();
        rst = 0;
        cycle();
        cycle();
        rst = 1;
        // Reset state.
        check("rst_commit_valid", 64'(commit_valid), 64'(0));
        check("rst_flush_valid", 64'(flush_valid), 64'(0));
        check("rst_ls_go", 64'(ls_go), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_alloc_tag", 64'(alloc_tag), 64'(1));

        // Single ALU instruction.
        idle(); set_alloc(0, 5); cycle();
        idle(); set_wb(0, 1, 32'h1234, 0, 0); cycle();
        idle(); cycle();
        check("s1_commit_valid", 64'(commit_valid), 64'(1));
        check("s1_commit_rd", 64'(commit_rd), 64'(5));
        check("s1_commit_value", 64'(commit_value), 64'h1234);
        check("s1_commit_tag", 64'(commit_tag), 64'(1));
        check("s1_count", 64'(count), 64'(0));

        // Fill, reverse-order writeback, in-order drain, tail wrap.
        do_reset();
        for (int i = 1; i <= 7; i++) begin idle(); set_alloc(0, i); cycle(); end
        check("full_ready", 64'(alloc_ready), 64'(0));
        check("full_count", 64'(count), 64'(7));
        for (int t = 7; t >= 1; t--) begin
            idle(); set_wb(0, t, 32'(t * 16'h0101), 0, 0); cycle();
        end
        got_tags.delete();
        idle(); set_alloc(0, 9); cycle();
        if (commit_valid) got_tags.push_back(int'(commit_tag));
        check("full_commit_refuses_alloc", 64'(count), 64'(6));
        for (int c = 0; c < 8; c++) begin
            idle(); cycle();
            if (commit_valid) got_tags.push_back(int'(commit_tag));
        end
        check("drain_n", 64'(got_tags.size()), 64'(7));
        for (int i = 0; i < got_tags.size() && i < 7; i++)
            check("drain_order", 64'(got_tags[i]), 64'(i + 1));
        check("wrap_alloc_tag", 64'(alloc_tag), 64'(1));
        check("drain_count", 64'(count), 64'(0));

        // MEM issue at head.
        do_reset();
        idle(); set_alloc(1, 9); cycle();
        idle(); cycle();
        check("mem_ls_go", 64'(ls_go), 64'(1));
        check("mem_ls_tag", 64'(ls_tag), 64'(1));
        idle(); cycle();
        check("mem_ls_go_pulse", 64'(ls_go), 64'(0));
        idle(); set_wb(1, 1, 32'hAA, 0, 0); cycle();
        idle(); cycle();
        check("mem_commit_valid", 64'(commit_valid), 64'(1));
        check("mem_commit_value", 64'(commit_value), 64'hAA);

        // Same-tag collision and forwarding.
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); set_alloc(0, 10 + i); cycle(); end
        idle();
        set_wb(0, 3, 32'h11, 0, 0); set_wb(1, 3, 32'h22, 0, 0);
        lk_tag_a = 3'd3;
        #1;
        check("fwd_rdy", 64'(lk_rdy_a), 64'(1));
        check("fwd_val", 64'(lk_val_a), 64'h11);
        cycle();
        idle(); lk_tag_a = 3'd3; lk_tag_b = 3'd2;
        #1;
        check("stored_rdy", 64'(lk_rdy_a), 64'(1));
        check("stored_val", 64'(lk_val_a), 64'h11);
        check("pending_rdy", 64'(lk_rdy_b), 64'(0));
        cycle();
        idle(); set_wb(0, 1, 32'h1, 0, 0); set_wb(1, 2, 32'h2, 0, 0); cycle();
        for (int c = 0; c < 4; c++) begin idle(); cycle(); end
        check("coll_count", 64'(count), 64'(0));

        // Mispredicted branch flush.
        do_reset();
        idle(); set_alloc(2, 1); cycle();
        for (int i = 0; i < 3; i++) begin idle(); set_alloc(0, 20 + i); cycle(); end
        idle(); set_wb(0, 1, 32'h104, 1, 32'h400); cycle();
        idle(); set_alloc(0, 7); set_wb(0, 2, 32'h55, 0, 0); cycle();
        check("fl_valid", 64'(flush_valid), 64'(1));
        check("fl_pc", 64'(flush_pc), 64'h400);
        check("fl_commit_valid", 64'(commit_valid), 64'(1));
        check("fl_commit_rd", 64'(commit_rd), 64'(1));
        check("fl_commit_value", 64'(commit_value), 64'h104);
        check("fl_count", 64'(count), 64'(0));
        check("fl_alloc_tag", 64'(alloc_tag), 64'(1));
        idle(); cycle();
        check("fl_pulse", 64'(flush_valid), 64'(0));
        idle(); set_wb(0, 3, 32'h77, 0, 0); cycle();
        for (int c = 0; c < 2; c++) begin
            idle(); cycle();
            check("fl_stale_wb", 64'(commit_valid), 64'(0));
        end
        check("fl_count_after", 64'(count), 64'(0));

        // Reset with completed entries behind a pending head.
        do_reset();
        for (int i = 0; i < 5; i++) begin idle(); set_alloc(0, i); cycle(); end
        idle(); set_wb(0, 2, 32'h2, 0, 0); set_wb(1, 3, 32'h3, 0, 0); cycle();
        idle(); set_wb(0, 4, 32'h4, 0, 0); set_wb(1, 5, 32'h5, 0, 0); cycle();
        do_reset();
        check("mr_count", 64'(count), 64'(0));
        check("mr_ready", 64'(alloc_ready), 64'(1));
        for (int c = 0; c < 3; c++) begin
            idle(); cycle();
            check("mr_no_commit", 64'(commit_valid), 64'(0));
        end

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            idle();
            rst = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(1) == 1) set_alloc($urandom_range(3), $urandom_range(31));
            for (int p = 0; p < WBP; p++) begin
                if ($urandom_range(1) == 1) begin
                    int t;
                    if (m_order.size() > 0 && $urandom_range(3) != 0)
                        t = m_order[$urandom_range(m_order.size() - 1)];
                    else
                        t = $urandom_range(7);
                    set_wb(p, t, $urandom, ($urandom_range(15) == 0), $urandom);
                end
            end
            lk_tag_a = 3'($urandom_range(7));
            lk_tag_b = 3'($urandom_range(7));
            cycle();
        end
        rst = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
